lcd_oam_dma_ctrl: RTL
=====================

# lcd_oam_dma_ctrl

OAM DMA controller for the LCD subsystem. A CPU write to register 0xFF46 starts a 160-byte copy from source page `{value, 8'h00}` into sprite attribute memory at 0xFE00–0xFE9F. The controller masters the source bus and the LCD RAM write port through the same active-low read/write strobe protocol the memory wrappers use. It asserts a busy flag so the bus router can lock the CPU out of non-HRAM space while the copy runs.

## Interface
- `BYTES`, 160: number of bytes copied per transfer.
- `REG_ADDR`, 16'hFF46: address of the DMA source register.
- `OAM_BASE`, 16'hFE00: destination base address.
- `I_CLK` in 1: memory clock. All state changes on its rising edge.
- `I_RESET_L` in 1: asynchronous, active-low reset.
- `I_REG_ADDR` in 16: CPU address.
- `I_REG_DIN` in 8: CPU write data.
- `I_REG_WE_L` in 1: CPU write strobe, active low.
- `I_REG_RE_L` in 1: CPU read strobe, active low.
- `O_REG_DOUT` in/out: out 8. Register readback.
- `O_SRC_ADDR` out 16: source read address.
- `O_SRC_RE_L` out 1: source read strobe, active low.
- `I_SRC_DATA` in 8: source read data, synchronous, valid the cycle after `O_SRC_RE_L` is low.
- `O_OAM_ADDR` out 16: destination address.
- `O_OAM_DATA` out 8: destination write data.
- `O_OAM_WE_L` out 1: destination write strobe, active low.
- `O_DMA_BUSY` out 1: high from the START state through the last WR state.

## Operation
- **Register**
  - 8-bit `src_hi` register, reset value 8'h00.
  - Loaded when `I_REG_WE_L`=0 and `I_REG_ADDR`==`REG_ADDR`.
  - `O_REG_DOUT` = `src_hi` when `I_REG_RE_L`=0 and the address matches; otherwise 8'hFF.
- **Source mapping**
  - Effective source high byte = `src_hi` − 8'h20 when `src_hi` ≥ 8'hE0 (echo-RAM mirror), else `src_hi`.
  - The mapped value is latched at start into `base_hi`.
- **Byte counter** `idx`: 8 bits, reset 0, counts 0 to `BYTES`−1.
- **States**: IDLE, START, RD, CAP, WR.
  - IDLE → START on a register write.
  - START: latch `base_hi`, clear `idx`. → RD.
  - RD: `O_SRC_ADDR`={`base_hi`,`idx`}, `O_SRC_RE_L`=0. → CAP.
  - CAP: hold the address, `O_SRC_RE_L`=1. Latch `I_SRC_DATA` into `dbuf` at the end of the cycle. → WR.
  - WR: `O_OAM_ADDR`=`OAM_BASE`+`idx`, `O_OAM_DATA`=`dbuf`, `O_OAM_WE_L`=0.
    - If `idx`==`BYTES`−1 → IDLE; else `idx`+1 → RD.
- **Restart**
  - A register write in any non-IDLE state forces START on the next cycle with the new value.
  - The cycle carrying the write still performs that state's strobe. A WR in progress commits its byte.
- **Idle outputs**: outside RD, `O_SRC_RE_L`=1; outside WR, `O_OAM_WE_L`=1. Addresses and data hold their last values. Strobes are never both low.
- **Arithmetic**: `OAM_BASE`+`idx` is a 16-bit add with `idx` zero-extended. No wrap occurs for `BYTES`≤256.

## Timing
- **Reset values**
  - State IDLE; `O_DMA_BUSY`=0.
  - `O_SRC_RE_L`=1, `O_OAM_WE_L`=1.
  - `O_SRC_ADDR`=0, `O_OAM_ADDR`=0, `O_OAM_DATA`=0, `src_hi`=0.
- **Reset mid-transfer**: immediately returns to the reset values. No further strobes.
- **Transfer length**
  - Register write at edge N → START in cycle N+1 → first RD in N+2.
  - Each byte takes 3 cycles (RD, CAP, WR).
  - Last WR falls in cycle N+1+3·`BYTES`, i.e. N+481 for 160 bytes.
  - `O_DMA_BUSY` falls at the following edge.
- **Write-back latency**: one source read is followed by exactly one destination write, 2 cycles later.
- **Back-to-back**: a write during the final WR is a restart. `O_DMA_BUSY` stays high with no IDLE gap.

## Test plan
- **Reset**: hold `I_RESET_L`=0 with random inputs → all strobes 1, busy 0, `O_REG_DOUT`=8'hFF unless 0xFF46 is read.
- **Full copy**
  - Write 8'hC1, source RAM `mem[C100+i]`=i^8'h5A.
  - Required: 160 WE pulses at FE00..FE9F with data i^8'h5A.
  - Busy high exactly 481 cycles; readback 8'hC1.
- **Echo mirror**: write 8'hE3 → reads from C300..C39F; `O_SRC_ADDR` never ≥ E000.
- **Restart mid-copy**
  - Write 8'hC1, then 8'hD0 when `idx`=37.
  - Required: FE00..FE24 hold C1-page data, then the copy restarts at FE00 from D000.
  - All 160 bytes end up D0-page data.
- **Reset mid-copy**: pull `I_RESET_L` low during a CAP state → strobes deassert in the same cycle, no further OAM writes. After release, a new write 8'hC2 performs a clean full copy.
- **Decode isolation**: writes to FF45/FF47 and reads of FF46 → no transfer starts, `src_hi` unchanged.

Source files
------------

// File: rtl/lcd_oam_dma_ctrl.sv
// -----------------------------------------------------------------------------
// lcd_oam_dma_ctrl
//
// OAM DMA engine. A CPU write to REG_ADDR copies BYTES bytes from the source
// page {value, 8'h00} into sprite attribute memory starting at OAM_BASE.
// Source values at or above 8'hE0 point into echo RAM and are folded down by
// 8'h20 before use.
//
// Ports:
//   I_CLK, I_RESET_L           memory clock, async active-low reset
//   I_REG_ADDR/DIN/WE_L/RE_L   CPU register port (strobes active low)
//   O_REG_DOUT                 register readback, 8'hFF when not selected
//   O_SRC_ADDR, O_SRC_RE_L     source read request
//   I_SRC_DATA                 source data, valid the cycle after the read strobe
//   O_OAM_ADDR/DATA/WE_L       OAM write port
//   O_DMA_BUSY                 high while a copy is in progress (START..last WR)
//   O_DBG_STATE                current FSM state (IDLE=0 START=1 RD=2 CAP=3 WR=4)
//
// Strobe protocol: a strobe low for one cycle is one transfer; the address
// (and for writes the data) is stable for the whole low cycle. A read strobe
// in cycle k returns data during cycle k+1. Read and write strobes are never
// low in the same cycle.
// -----------------------------------------------------------------------------
module lcd_oam_dma_ctrl #(
  parameter int          BYTES    = 160,
  parameter logic [15:0] REG_ADDR = 16'hFF46,
  parameter logic [15:0] OAM_BASE = 16'hFE00
) (
  input  logic        I_CLK,
  input  logic        I_RESET_L,
  input  logic [15:0] I_REG_ADDR,
  input  logic [7:0]  I_REG_DIN,
  input  logic        I_REG_WE_L,
  input  logic        I_REG_RE_L,
  output logic [7:0]  O_REG_DOUT,
  output logic [15:0] O_SRC_ADDR,
  output logic        O_SRC_RE_L,
  input  logic [7:0]  I_SRC_DATA,
  output logic [15:0] O_OAM_ADDR,
  output logic [7:0]  O_OAM_DATA,
  output logic        O_OAM_WE_L,
  output logic        O_DMA_BUSY,
  output logic [2:0]  O_DBG_STATE
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_RD    = 3'd2,
    S_CAP   = 3'd3,
    S_WR    = 3'd4
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(BYTES - 1);

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_src_hi;
  logic [7:0]  r_base_hi;
  logic [7:0]  r_idx;
  logic [7:0]  r_dbuf;
  logic [15:0] r_src_addr;
  logic [15:0] r_oam_addr;
  logic        w_reg_sel;
  logic        w_reg_wr;
  logic [7:0]  w_mapped_hi;

  assign w_reg_sel = (I_REG_ADDR == REG_ADDR);
  assign w_reg_wr  = !I_REG_WE_L && w_reg_sel;

  // Echo RAM E000-FDFF mirrors C000-DDFF.
  assign w_mapped_hi = (r_src_hi >= 8'hE0) ? (r_src_hi - 8'h20) : r_src_hi;

  // Next-state logic. A register write always wins, so a write in any state
  // (including the final WR) restarts the copy without passing through IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = S_IDLE;
      S_START: w_next = S_RD;
      S_RD:    w_next = S_CAP;
      S_CAP:   w_next = S_WR;
      S_WR:    w_next = (r_idx == LAST_IDX) ? S_IDLE : S_RD;
      default: w_next = S_IDLE;
    endcase
    if (w_reg_wr) begin
      w_next = S_START;
    end
  end

  always_ff @(posedge I_CLK or negedge I_RESET_L) begin
    if (!I_RESET_L) begin
      r_state    <= S_IDLE;
      r_src_hi   <= 8'h00;
      r_base_hi  <= 8'h00;
      r_idx      <= 8'h00;
      r_dbuf     <= 8'h00;
      r_src_addr <= 16'h0000;
      r_oam_addr <= 16'h0000;
    end else begin
      r_state <= w_next;
      if (w_reg_wr) begin
        r_src_hi <= I_REG_DIN;
      end
      if (r_state == S_START) begin
        r_base_hi <= w_mapped_hi;
        r_idx     <= 8'h00;
      end else if (r_state == S_WR && r_idx != LAST_IDX) begin
        r_idx <= r_idx + 8'd1;
      end
      // Address/data registers are loaded on the edge that enters the state
      // using them, so they are valid for the whole strobe cycle and hold
      // their values afterwards. RD is only entered from START or WR.
      if (w_next == S_RD) begin
        r_src_addr <= (r_state == S_START) ? {w_mapped_hi, 8'h00}
                                           : {r_base_hi, r_idx + 8'd1};
      end
      if (r_state == S_CAP && w_next == S_WR) begin
        r_dbuf     <= I_SRC_DATA;
        r_oam_addr <= OAM_BASE + {8'h00, r_idx};
      end
    end
  end

  assign O_REG_DOUT  = (!I_REG_RE_L && w_reg_sel) ? r_src_hi : 8'hFF;
  assign O_SRC_ADDR  = r_src_addr;
  assign O_SRC_RE_L  = (r_state != S_RD);
  assign O_OAM_ADDR  = r_oam_addr;
  assign O_OAM_DATA  = r_dbuf;
  assign O_OAM_WE_L  = (r_state != S_WR);
  assign O_DMA_BUSY  = (r_state != S_IDLE);
  assign O_DBG_STATE = r_state;

endmodule
